// File: rtl/mul_seq_if.sv
// Operand/product streams and multiplier bus signals for mul_seq.
// The master modport is the sequencer's side; slave is the upstream/consumer/multiplier side.
interface mul_seq_if #(
  parameter int SZin = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [SZin-1:0]   in_a;
  logic [SZin-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*SZin-1:0] out_p;
  logic              m_sel;
  logic              m_wrt;
  logic              m_nres;
  logic              m_addr_b;
  logic [SZin-1:0]   m_wdata;
  logic [2*SZin-1:0] m_rdata;
  logic              m_ready;

  modport master (
    input  in_valid, in_a, in_b, out_ready, m_rdata, m_ready,
    output in_ready, out_valid, out_p, m_sel, m_wrt, m_nres, m_addr_b, m_wdata
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, m_rdata, m_ready,
    input  in_ready, out_valid, out_p, m_sel, m_wrt, m_nres, m_addr_b, m_wdata
  );
endinterface

// File: rtl/mul_seq.sv
// Operand sequencer for the two's-complement multiplier: write a, write b, read product.
// Optional bus timeout with sticky err is enabled by defining MUL_SEQ_TIMEOUT_EN.
module mul_seq #(
  parameter int SZin = 8,
  parameter int CW   = 8,
  parameter int TMO  = 15
) (
  input  logic          clk,
  input  logic          res,
  mul_seq_if.master     bus,
  output logic [CW-1:0] done_cnt,
  output logic          err
);

  typedef enum logic [2:0] {CLR, IDLE, WR_A, WR_B, RD, RD_CAP, OUT} state_t;

  state_t          state, state_nxt;
  logic [SZin-1:0] b_reg;
  logic            accept, take_out, tmo_fire, tmo_hit;

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent waiting in a bus state; cleared whenever the state changes.
  always_ff @(posedge clk) begin
    if (res) begin
      tmo_cnt <= '0;
    end else if (state_nxt != state) begin
      tmo_cnt <= '0;
    end else if (state inside {WR_A, WR_B, RD}) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
`else
  // Without the timeout the bus waits forever; TMO is only kept for a common parameter list.
  assign tmo_hit = (TMO < 0);
`endif

  // m_ready is tested with a plain if so that x/z fall through to "not ready".
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take_out  = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      CLR:    if (bus.m_sel) state_nxt = IDLE;
      IDLE:   if (bus.in_valid && bus.in_ready) begin
                accept    = 1'b1;
                state_nxt = WR_A;
              end
      WR_A:   if (bus.m_ready) state_nxt = WR_B;
              else if (tmo_hit) begin
                tmo_fire  = 1'b1;
                state_nxt = CLR;
              end
      WR_B:   if (bus.m_ready) state_nxt = RD;
              else if (tmo_hit) begin
                tmo_fire  = 1'b1;
                state_nxt = CLR;
              end
      RD:     if (bus.m_ready) state_nxt = RD_CAP;
              else if (tmo_hit) begin
                tmo_fire  = 1'b1;
                state_nxt = CLR;
              end
      RD_CAP: state_nxt = OUT;
      OUT:    if (bus.out_ready) begin
                take_out  = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = CLR;
    endcase
  end

  // Outputs are registered from the next state, so each holds for the whole state.
  // Coming out of reset CLR first idles one cycle with everything low, then pulses the clear.
  always_ff @(posedge clk) begin
    if (res) begin
      state         <= CLR;
      b_reg         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_p     <= '0;
      bus.m_sel     <= 1'b0;
      bus.m_wrt     <= 1'b0;
      bus.m_nres    <= 1'b0;
      bus.m_addr_b  <= 1'b0;
      bus.m_wdata   <= '0;
      done_cnt      <= '0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.in_ready  <= (state_nxt == IDLE);
      bus.out_valid <= (state_nxt == OUT);
      bus.m_sel     <= (state_nxt inside {CLR, WR_A, WR_B, RD});
      bus.m_wrt     <= (state_nxt inside {WR_A, WR_B});
      bus.m_nres    <= (state_nxt != CLR);
      if (accept) begin
        b_reg        <= bus.in_b;
        bus.m_addr_b <= 1'b0;
        bus.m_wdata  <= bus.in_a;
      end
      if (state == WR_A && state_nxt == WR_B) begin
        bus.m_addr_b <= 1'b1;
        bus.m_wdata  <= b_reg;
      end
      if (state == RD_CAP) bus.out_p <= bus.m_rdata;
      if (take_out) done_cnt <= done_cnt + CW'(1);
      if (tmo_fire) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with a behavioural signed multiplier on the bus.
// Timeout scenario runs only when MUL_SEQ_TIMEOUT_EN is defined.
module tb_mul_seq;

  logic       clk = 1'b0;
  logic       res;
  logic       mready;
  logic [7:0] done_cnt;
  logic       err;
  int         checks   = 0;
  int         failures = 0;
  int         wr_cnt   = 0;

  logic signed [7:0]  op0 = '0;
  logic signed [7:0]  op1 = '0;
  logic signed [15:0] prod;

  mul_seq_if #(.SZin(8)) bus ();

  mul_seq #(.SZin(8), .CW(8), .TMO(15)) dut (
    .clk      (clk),
    .res      (res),
    .bus      (bus),
    .done_cnt (done_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  assign bus.m_ready = mready;
  assign prod        = op0 * op1;
  assign bus.m_rdata = prod;

  // Multiplier model: stores an operand on each accepted write.
  always @(posedge clk) begin
    if (bus.m_sel && bus.m_wrt && mready) begin
      if (bus.m_addr_b) op1 <= bus.m_wdata;
      else              op0 <= bus.m_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_pair(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] p, output int lat, output bit tmo);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
    end
    cycle();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      cycle();
      lat++;
    end
    tmo = (bus.out_valid !== 1'b1);
    p   = bus.out_p;
  endtask

  task automatic test_reset();
    res = 1'b1; mready = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    cycle(); cycle();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.m_sel, bus.m_wrt, bus.m_nres, bus.m_addr_b, err} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {bus.in_ready, bus.out_valid, bus.m_sel, bus.m_wrt, bus.m_nres, bus.m_addr_b, err});
    end
    checks++;
    if ({bus.out_p, done_cnt, bus.m_wdata} !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 0", {bus.out_p, done_cnt, bus.m_wdata});
    end
    res = 1'b0;
    cycle();
    checks++;
    if ({bus.m_sel, bus.m_nres, bus.in_ready} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL clear_pulse: got sel/nres/rdy=%b expected 100", {bus.m_sel, bus.m_nres, bus.in_ready});
    end
    cycle();
    checks++;
    if ({bus.in_ready, bus.m_sel, bus.m_nres} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL idle_after_clr: got rdy/sel/nres=%b expected 101", {bus.in_ready, bus.m_sel, bus.m_nres});
    end
  endtask

  task automatic test_single();
    bus.in_a = 8'h03; bus.in_b = 8'hFE; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.m_sel, bus.m_wrt, bus.m_addr_b, bus.m_wdata} !== {3'b110, 8'h03}) begin
      failures++;
      $display("[TB] FAIL bus_wr_a: got %b_%h expected 110_03", {bus.m_sel, bus.m_wrt, bus.m_addr_b}, bus.m_wdata);
    end
    cycle();
    checks++;
    if ({bus.m_sel, bus.m_wrt, bus.m_addr_b, bus.m_wdata} !== {3'b111, 8'hFE}) begin
      failures++;
      $display("[TB] FAIL bus_wr_b: got %b_%h expected 111_fe", {bus.m_sel, bus.m_wrt, bus.m_addr_b}, bus.m_wdata);
    end
    cycle();
    checks++;
    if ({bus.m_sel, bus.m_wrt, bus.in_ready} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL bus_rd: got sel/wrt/rdy=%b expected 100", {bus.m_sel, bus.m_wrt, bus.in_ready});
    end
    cycle();
    checks++;
    if ({bus.m_sel, bus.out_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rd_cap: got sel/ovld=%b expected 00", {bus.m_sel, bus.out_valid});
    end
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_p} !== {1'b1, 16'hFFFA}) begin
      failures++;
      $display("[TB] FAIL single_prod: got vld=%b p=%h expected vld=1 p=fffa", bus.out_valid, bus.out_p);
    end
    consume();
    checks++;
    if ({bus.out_valid, bus.in_ready, done_cnt} !== {2'b01, 8'd1}) begin
      failures++;
      $display("[TB] FAIL single_done: got vld/rdy=%b cnt=%0d expected 01 cnt=1", {bus.out_valid, bus.in_ready}, done_cnt);
    end
  endtask

  task automatic test_stall();
    logic [11:0] exp_snap [3] = '{12'hE07, 12'hFF7, 12'hBF7};
    logic [11:0] snap;
    int lat, moved;
    bus.in_a = 8'd7; bus.in_b = 8'hF7; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    lat = 0;
    for (int s = 0; s < 3; s++) begin
      mready = 1'b0;
      snap = {bus.m_sel, bus.m_wrt, bus.m_nres, bus.m_addr_b, bus.m_wdata};
      checks++;
      if (snap !== exp_snap[s]) begin
        failures++;
        $display("[TB] FAIL stall_lines_%0d: got %h expected %h", s, snap, exp_snap[s]);
      end
      moved = 0;
      repeat (5) begin
        cycle();
        lat++;
        if ({bus.m_sel, bus.m_wrt, bus.m_nres, bus.m_addr_b, bus.m_wdata} !== snap) moved++;
      end
      checks++;
      if (moved !== 0) begin
        failures++;
        $display("[TB] FAIL stall_stable_%0d: got %0d changed cycles expected 0", s, moved);
      end
      mready = 1'b1;
      cycle();
      lat++;
    end
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      cycle();
      lat++;
    end
    checks++;
    if (lat !== 19 || bus.out_p !== 16'hFFC1) begin
      failures++;
      $display("[TB] FAIL stall_result: got lat=%0d p=%h expected lat=19 p=ffc1", lat, bus.out_p);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    int lat, w0;
    bit tmo;
    do_pair(8'd4, 8'd5, p, lat, tmo);
    checks++;
    if (tmo || p !== 16'h0014 || lat !== 4) begin
      failures++;
      $display("[TB] FAIL bp_first: got tmo=%0d lat=%0d p=%h expected tmo=0 lat=4 p=0014", tmo, lat, p);
    end
    bus.in_a = 8'd2; bus.in_b = 8'd3; bus.in_valid = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_p} !== {2'b10, 16'h0014} || wr_cnt !== w0) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d: got vld/rdy=%b p=%h writes=%0d expected 10 p=0014 writes=%0d",
                 i, {bus.out_valid, bus.in_ready}, bus.out_p, wr_cnt, w0);
      end
    end
    consume();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_p, done_cnt} !== {2'b01, 16'h0014, 8'd3}) begin
      failures++;
      $display("[TB] FAIL bp_release: got vld/rdy=%b p=%h cnt=%0d expected 01 p=0014 cnt=3",
               {bus.out_valid, bus.in_ready}, bus.out_p, done_cnt);
    end
    cycle();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      cycle();
      lat++;
    end
    checks++;
    if (lat !== 4 || bus.out_p !== 16'h0006) begin
      failures++;
      $display("[TB] FAIL bp_second: got lat=%0d p=%h expected lat=4 p=0006", lat, bus.out_p);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    bit tmo;
    bus.in_a = 8'd9; bus.in_b = 8'd9; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    checks++;
    if ({bus.m_sel, bus.m_wrt, bus.m_addr_b} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL mid_in_wr_b: got %b expected 111", {bus.m_sel, bus.m_wrt, bus.m_addr_b});
    end
    res = 1'b1;
    cycle();
    res = 1'b0;
    checks++;
    if ({bus.out_valid, bus.m_nres, done_cnt} !== {2'b00, 8'd0}) begin
      failures++;
      $display("[TB] FAIL mid_reset: got vld/nres=%b cnt=%0d expected 00 cnt=0", {bus.out_valid, bus.m_nres}, done_cnt);
    end
    cycle();
    checks++;
    if ({bus.m_sel, bus.m_nres, bus.out_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL mid_clr: got sel/nres/vld=%b expected 100", {bus.m_sel, bus.m_nres, bus.out_valid});
    end
    do_pair(8'd5, 8'd5, p, lat, tmo);
    checks++;
    if (tmo || p !== 16'h0019 || lat !== 4) begin
      failures++;
      $display("[TB] FAIL mid_next_pair: got tmo=%0d lat=%0d p=%h expected tmo=0 lat=4 p=0019", tmo, lat, p);
    end
    consume();
    checks++;
    if (done_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL mid_done: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] p;
    logic [7:0]  a;
    int lat, bad, e;
    bit tmo;
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      a = 8'(i);
      e = $signed(a) * 3;
      do_pair(a, 8'd3, p, lat, tmo);
      if (tmo || p !== 16'(e)) bad++;
      consume();
    end
    checks++;
    if (bad !== 0 || done_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL wrap_255: got bad=%0d cnt=%0d expected bad=0 cnt=255", bad, done_cnt);
    end
    do_pair(8'h80, 8'h80, p, lat, tmo);
    checks++;
    if (tmo || p !== 16'h4000) begin
      failures++;
      $display("[TB] FAIL wrap_minmin: got tmo=%0d p=%h expected tmo=0 p=4000", tmo, p);
    end
    consume();
    checks++;
    if (done_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL wrap_zero: got %0d expected 0", done_cnt);
    end
  endtask

`ifdef MUL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] p;
    int lat;
    bit tmo;
    bus.in_a = 8'd2; bus.in_b = 8'd2; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle(); cycle();
    mready = 1'b0;
    repeat (14) cycle();
    checks++;
    if ({err, bus.m_sel, bus.m_wrt} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL tmo_before: got err/sel/wrt=%b expected 010", {err, bus.m_sel, bus.m_wrt});
    end
    cycle();
    checks++;
    if ({err, bus.m_sel, bus.m_nres, done_cnt} !== {3'b110, 8'd0}) begin
      failures++;
      $display("[TB] FAIL tmo_fire: got err/sel/nres=%b cnt=%0d expected 110 cnt=0", {err, bus.m_sel, bus.m_nres}, done_cnt);
    end
    mready = 1'b1;
    do_pair(8'd6, 8'd7, p, lat, tmo);
    checks++;
    if (tmo || p !== 16'h002A) begin
      failures++;
      $display("[TB] FAIL tmo_recover: got tmo=%0d p=%h expected tmo=0 p=002a", tmo, p);
    end
    consume();
    checks++;
    if ({err, done_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL tmo_sticky: got err=%b cnt=%0d expected err=1 cnt=1", err, done_cnt);
    end
    res = 1'b1;
    cycle();
    res = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_clear: got err=%b expected 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_wrap();
`ifdef MUL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Operand sequencer directly upstream of the two's-complement multiplier peripheral. Accepts signed operand pairs on a valid/ready stream and runs the multiplier bus protocol: write operand 0, write operand 1, read product. Returns the 2*SZin-bit product on a valid/ready output stream. It is the sole master of the multiplier's select/write/address/data lines and issues the multiplier's clear after reset.

## Interface
- SZin, 8, operand width; product width 2*SZin
- CW, 8, width of completed-product counter
- TMO, 15, bus timeout in cycles (used only with MUL_SEQ_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- res  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a  in  SZin  operand 0 (signed)
- in_b  in  SZin  operand 1 (signed)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2*SZin  product as read from multiplier
- done_cnt  out  CW  products delivered, wraps
- err  out  1  sticky bus-timeout flag
- m_sel  out  1  multiplier select
- m_wrt  out  1  1 = write operand, 0 = read product
- m_nres  out  1  multiplier clear, active low
- m_addr_b  out  1  operand address (0/1)
- m_wdata  out  SZin  operand data to multiplier
- m_rdata  in  2*SZin  product from multiplier
- m_ready  in  1  multiplier ready; only 1'b1 counts as ready (0, x, z = not ready)

## Operation
- States: CLR, IDLE, WR_A, WR_B, RD, RD_CAP, OUT.
- Reset: all outputs 0 (m_nres=0, in_ready=0, out_valid=0, out_p=0, done_cnt=0, err=0). State CLR.
- CLR: m_sel=1, m_nres=0, m_wrt=0 for exactly one cycle. Then IDLE.
- IDLE: m_sel=0, m_nres=1, in_ready=1. On in_valid&in_ready: latch in_a/in_b into internal registers, go to WR_A.
- WR_A: m_sel=1, m_wrt=1, m_addr_b=0, m_wdata=latched a. On m_ready==1: go to WR_B.
- WR_B: same as WR_A with m_addr_b=1, m_wdata=latched b. On m_ready==1: go to RD.
- RD: m_sel=1, m_wrt=0. On m_ready==1: go to RD_CAP.
- RD_CAP: m_sel=0. out_p <= m_rdata on this edge. Go to OUT.
- OUT: out_valid=1, out_p held stable. On out_ready: done_cnt <= done_cnt+1 (mod 2^CW), go to IDLE.
- All m_* outputs are registered. They hold their values for the whole state.
- m_wdata and m_addr_b change only on state entry.
- No arithmetic on the product: out_p is m_rdata bit-for-bit.

## Timing
- in_ready=1 only in IDLE. No acceptance while busy; upstream holds its data.
- Minimum latency, m_ready constantly 1:
  - accept at edge 0;
  - WR_A done edge 1, WR_B edge 2, RD edge 3, capture edge 4;
  - out_valid high after edge 4.
- Minimum period between accepts: 6 cycles (out_ready=1).
- m_ready stall extends the current bus state indefinitely (unless timeout is enabled). No bus line toggles during a stall.
- out_valid drops the cycle after handshake. out_p keeps its last value until the next capture.
- done_cnt wraps from 2^CW-1 to 0.
- res mid-operation (any state): the pair in flight is dropped, out_valid=0, and the block goes to CLR. The multiplier is re-cleared. done_cnt=0 and err=0.
- res takes priority over every handshake on the same edge.

## Configuration
- MUL_SEQ_TIMEOUT_EN defined:
  - A counter runs in WR_A/WR_B/RD and resets on every state entry.
  - After TMO consecutive cycles with m_ready!=1: err <= 1 (sticky until res), pair dropped, go to CLR.
  - done_cnt is not incremented.
- MUL_SEQ_TIMEOUT_EN undefined: no counter, err tied 0, unlimited wait.

## Test plan
- Reset/clear: assert res 2 cycles, release.
  - During reset: all outputs 0.
  - First cycle after release: m_sel=1, m_nres=0.
  - Next cycle: IDLE with in_ready=1.
- Single product, ready always 1: in_a=3, in_b=-2 (SZin=8), model returns signed product.
  - Bus sequence observed: addr 0 data 0x03, then addr 1 data 0xFE, then read.
  - out_valid after 4 edges, out_p=0xFFFA, done_cnt=1.
- Stalls: hold m_ready=0 for 5 cycles in each of WR_A, WR_B, RD.
  - m_* lines stay stable throughout.
  - Result is correct; latency = 4+15 cycles.
- Backpressure: out_ready=0 for 10 cycles with in_valid held high.
  - out_valid and out_p stay stable, in_ready=0, no second bus write.
  - After out_ready rises, the next pair is accepted.
- Reset mid-operation: assert res while in WR_B.
  - Next cycle is CLR; no out_valid, done_cnt=0.
  - A following pair 5×5 yields out_p=25.
- Timeout (macro defined, TMO=15): m_ready stuck at 0 in RD.
  - At cycle 15: err=1, state CLR, done_cnt unchanged.
  - err stays 1 through later successful products until res.
